// File: rtl/pcie_dma_txarb.sv
// pcie_dma_txarb: packet-granular round-robin arbiter sharing one PCIe DMA TX FIFO write port
// Optional per-requester packet counters are enabled by defining PCIE_DMA_TXARB_STATS_EN.
module pcie_dma_txarb #(
  parameter int CFG_MAX_BEATS = 64,
  localparam int TXFIFO_WIDTH = 73
) (
  input  logic                    i_clk,
  input  logic                    i_nrst,
  input  logic                    i_req0_valid,
  input  logic [63:0]             i_req0_data,
  input  logic [7:0]              i_req0_strob,
  input  logic                    i_req0_last,
  output logic                    o_req0_ready,
  input  logic                    i_req1_valid,
  input  logic [63:0]             i_req1_data,
  input  logic [7:0]              i_req1_strob,
  input  logic                    i_req1_last,
  output logic                    o_req1_ready,
  output logic [TXFIFO_WIDTH-1:0] o_txfifo_wdata,
  output logic                    o_txfifo_we,
  input  logic                    i_txfifo_full,
  output logic [1:0]              o_grant,
  output logic                    o_err_len
`ifdef PCIE_DMA_TXARB_STATS_EN
  ,
  output logic [31:0]             o_pkt_cnt0,
  output logic [31:0]             o_pkt_cnt1
`endif
);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  localparam logic [15:0] MAX_BEATS = 16'(CFG_MAX_BEATS);
  state_t      state;
  logic        prio;
  logic [15:0] beat_cnt;
  logic [15:0] cnt_nxt;
  logic        sel1;
  logic        busy;
  logic        cur_valid;
  logic        cur_last;
  logic        pick1;
  logic        done;
  assign sel1      = state == GNT1;
  assign busy      = state != IDLE;
  assign cur_valid = sel1 ? i_req1_valid : i_req0_valid;
  assign cur_last  = sel1 ? i_req1_last : i_req0_last;
  // Both requesting: the one not served last wins
  assign pick1     = (i_req0_valid & i_req1_valid) ? prio : i_req1_valid;
  assign cnt_nxt   = (beat_cnt == 16'hffff) ? beat_cnt : beat_cnt + 16'd1;
  assign o_req0_ready   = (state == GNT0) & ~i_txfifo_full;
  assign o_req1_ready   = sel1 & ~i_txfifo_full;
  assign o_txfifo_we    = busy & cur_valid & ~i_txfifo_full;
  assign o_txfifo_wdata = ~busy ? '0 :
                          sel1  ? {i_req1_data, i_req1_strob, i_req1_last}
                                : {i_req0_data, i_req0_strob, i_req0_last};
  assign done = o_txfifo_we & cur_last;
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state     <= IDLE;
      o_grant   <= '0;
      prio      <= 1'b0;
      beat_cnt  <= '0;
      o_err_len <= 1'b0;
    end else if (!busy) begin
      if (i_req0_valid | i_req1_valid) begin
        state   <= pick1 ? GNT1 : GNT0;
        o_grant <= pick1 ? 2'b10 : 2'b01;
      end
    end else if (done) begin
      state    <= IDLE;
      o_grant  <= '0;
      prio     <= ~sel1;
      beat_cnt <= '0;
    end else if (o_txfifo_we) begin
      beat_cnt  <= cnt_nxt;
      o_err_len <= o_err_len | (cnt_nxt == MAX_BEATS);
    end
  end
`ifdef PCIE_DMA_TXARB_STATS_EN
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      o_pkt_cnt0 <= '0;
      o_pkt_cnt1 <= '0;
    end else begin
      o_pkt_cnt0 <= o_pkt_cnt0 + 32'(done & ~sel1);
      o_pkt_cnt1 <= o_pkt_cnt1 + 32'(done & sel1);
    end
  end
`endif
endmodule

// File: tb/tb_pcie_dma_txarb.sv
// tb_pcie_dma_txarb: scoreboard bench for pcie_dma_txarb (DUT built with CFG_MAX_BEATS=4)
module tb_pcie_dma_txarb;
  logic        i_clk = 1'b0;
  logic        i_nrst = 1'b0;
  logic        i_req0_valid = 1'b0;
  logic [63:0] i_req0_data = '0;
  logic [7:0]  i_req0_strob = '0;
  logic        i_req0_last = 1'b0;
  logic        o_req0_ready;
  logic        i_req1_valid = 1'b0;
  logic [63:0] i_req1_data = '0;
  logic [7:0]  i_req1_strob = '0;
  logic        i_req1_last = 1'b0;
  logic        o_req1_ready;
  logic [72:0] o_txfifo_wdata;
  logic        o_txfifo_we;
  logic        i_txfifo_full = 1'b0;
  logic [1:0]  o_grant;
  logic        o_err_len;
`ifdef PCIE_DMA_TXARB_STATS_EN
  logic [31:0] o_pkt_cnt0;
  logic [31:0] o_pkt_cnt1;
`endif
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [72:0] q0[$];
  logic [72:0] q1[$];
  int own[$];
  int wcyc[$];
  pcie_dma_txarb #(.CFG_MAX_BEATS(4)) dut (
    .i_clk(i_clk), .i_nrst(i_nrst),
    .i_req0_valid(i_req0_valid), .i_req0_data(i_req0_data), .i_req0_strob(i_req0_strob),
    .i_req0_last(i_req0_last), .o_req0_ready(o_req0_ready),
    .i_req1_valid(i_req1_valid), .i_req1_data(i_req1_data), .i_req1_strob(i_req1_strob),
    .i_req1_last(i_req1_last), .o_req1_ready(o_req1_ready),
    .o_txfifo_wdata(o_txfifo_wdata), .o_txfifo_we(o_txfifo_we), .i_txfifo_full(i_txfifo_full),
    .o_grant(o_grant), .o_err_len(o_err_len)
`ifdef PCIE_DMA_TXARB_STATS_EN
    , .o_pkt_cnt0(o_pkt_cnt0), .o_pkt_cnt1(o_pkt_cnt1)
`endif
  );
  always #5 i_clk = ~i_clk;
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  // Scoreboard: every FIFO write is matched against the granted requester's expected queue
  always @(negedge i_clk) begin
    logic [72:0] e;
    #3;
    cyc++;
    if (o_txfifo_we) begin
      checks++;
      if (o_grant == 2'b01 && q0.size() > 0) begin
        e = q0.pop_front();
        own.push_back(0);
      end else if (o_grant == 2'b10 && q1.size() > 0) begin
        e = q1.pop_front();
        own.push_back(1);
      end else begin
        e = 'x;
        own.push_back(-1);
      end
      wcyc.push_back(cyc);
      if (o_txfifo_wdata !== e) begin
        failures++;
        $display("FAIL write_data grant=%b got=%h exp=%h", o_grant, o_txfifo_wdata, e);
      end
    end
  end
  task automatic set_req(input int k, input logic v, input logic [63:0] d, input logic [7:0] s, input logic l);
    if (k == 0) begin
      i_req0_valid = v; i_req0_data = d; i_req0_strob = s; i_req0_last = l;
    end else begin
      i_req1_valid = v; i_req1_data = d; i_req1_strob = s; i_req1_last = l;
    end
  endtask
  task automatic send(input int k, input int n, input logic [63:0] base);
    for (int b = 0; b < n; b++) begin
      logic [63:0] d;
      logic [7:0] s;
      logic l;
      int w;
      d = base + 64'(b);
      s = 8'(b * 37 + k);
      l = (b == n - 1);
      set_req(k, 1'b1, d, s, l);
      if (k == 0) q0.push_back({d, s, l}); else q1.push_back({d, s, l});
      w = 0;
      #1;
      while (!(k == 0 ? o_req0_ready : o_req1_ready)) begin
        @(negedge i_clk);
        #1;
        w++;
        if (w > 200) begin
          checks++;
          failures++;
          $display("FAIL ready_timeout req%0d beat=%0d got=0 exp=1", k, b);
          set_req(k, 1'b0, '0, '0, 1'b0);
          return;
        end
      end
      @(negedge i_clk);
    end
    set_req(k, 1'b0, '0, '0, 1'b0);
  endtask
  task automatic clear_logs();
    own.delete();
    wcyc.delete();
  endtask
  task automatic check_drained(input string name);
    repeat (3) @(negedge i_clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("FAIL %s_drained got q0=%0d q1=%0d exp 0 0", name, q0.size(), q1.size());
    end
  endtask
  task automatic check_owners(input string name, input int exp[$]);
    checks++;
    if (own != exp) begin
      failures++;
      $display("FAIL %s_owners got=%p exp=%p", name, own, exp);
    end
  endtask
  task automatic test_reset();
    i_nrst = 1'b0;
    repeat (2) @(negedge i_clk);
    i_nrst = 1'b1;
    repeat (10) begin
      @(negedge i_clk);
      #2;
      checks++;
      if ({o_grant, o_txfifo_we, o_req0_ready, o_req1_ready, o_err_len, o_txfifo_wdata} !== '0) begin
        failures++;
        $display("FAIL reset_idle got grant=%b we=%b r0=%b r1=%b err=%b wdata=%h exp all 0",
                 o_grant, o_txfifo_we, o_req0_ready, o_req1_ready, o_err_len, o_txfifo_wdata);
      end
    end
`ifdef PCIE_DMA_TXARB_STATS_EN
    checks++;
    if (o_pkt_cnt0 !== 0 || o_pkt_cnt1 !== 0) begin
      failures++;
      $display("FAIL reset_stats got %0d %0d exp 0 0", o_pkt_cnt0, o_pkt_cnt1);
    end
`endif
  endtask
  task automatic test_both_3beat();
    clear_logs();
    fork
      send(0, 3, 64'h1000_0000_0000_0000);
      send(1, 3, 64'h2000_0000_0000_0000);
    join
    check_drained("both_3beat");
    check_owners("both_3beat", '{0, 0, 0, 1, 1, 1});
    checks++;
    if (wcyc.size() != 6 || wcyc[1] - wcyc[0] != 1 || wcyc[2] - wcyc[1] != 1 ||
        wcyc[3] - wcyc[2] != 2 || wcyc[5] - wcyc[3] != 2) begin
      failures++;
      $display("FAIL both_3beat_timing got=%p exp gaps 1,1,2,1,1", wcyc);
    end
  endtask
  task automatic test_round_robin();
    clear_logs();
    fork
      for (int i = 0; i < 4; i++) send(0, 1, 64'h3000_0000_0000_0000 + 64'(i));
      for (int i = 0; i < 4; i++) send(1, 1, 64'h4000_0000_0000_0000 + 64'(i));
    join
    check_drained("round_robin");
    check_owners("round_robin", '{0, 1, 0, 1, 0, 1, 0, 1});
  endtask
  task automatic test_full_stall();
    clear_logs();
    fork
      send(1, 3, 64'h5000_0000_0000_0000);
      begin
        int w;
        int st;
        st = own.size();
        w = 0;
        while (own.size() != st + 1 && w < 50) begin
          @(negedge i_clk);
          w++;
        end
        i_txfifo_full = 1'b1;
        repeat (5) begin
          #2;
          checks++;
          if (o_req1_ready !== 1'b0 || o_txfifo_we !== 1'b0 || o_grant !== 2'b10) begin
            failures++;
            $display("FAIL full_stall got r1=%b we=%b grant=%b exp 0 0 10", o_req1_ready, o_txfifo_we, o_grant);
          end
          @(negedge i_clk);
        end
        i_txfifo_full = 1'b0;
      end
    join
    check_drained("full_stall");
    check_owners("full_stall", '{1, 1, 1});
  endtask
  task automatic test_err_len();
    clear_logs();
    fork
      send(0, 6, 64'h6000_0000_0000_0000);
      repeat (12) begin
        @(negedge i_clk);
        #2;
        checks++;
        if (o_err_len !== (own.size() >= 4)) begin
          failures++;
          $display("FAIL err_len got=%b exp=%b after %0d beats", o_err_len, own.size() >= 4, own.size());
        end
      end
    join
    check_drained("err_len");
    check_owners("err_len", '{0, 0, 0, 0, 0, 0});
  endtask
  task automatic test_reset_mid_packet();
    int w;
    clear_logs();
    set_req(0, 1'b1, 64'h7000_0000_0000_0001, 8'hf0, 1'b0);
    q0.push_back({64'h7000_0000_0000_0001, 8'hf0, 1'b0});
    w = 0;
    #1;
    while (!o_req0_ready && w < 50) begin
      @(negedge i_clk);
      #1;
      w++;
    end
    @(negedge i_clk);
    set_req(0, 1'b1, 64'h7000_0000_0000_0002, 8'h0f, 1'b0);
    q0.push_back({64'h7000_0000_0000_0002, 8'h0f, 1'b0});
    #1;
    i_nrst = 1'b0;
    @(negedge i_clk);
    set_req(0, 1'b0, '0, '0, 1'b0);
    #2;
    checks++;
    if ({o_grant, o_txfifo_we, o_req0_ready, o_req1_ready, o_err_len, o_txfifo_wdata} !== '0) begin
      failures++;
      $display("FAIL reset_mid got grant=%b we=%b r0=%b r1=%b err=%b exp all 0",
               o_grant, o_txfifo_we, o_req0_ready, o_req1_ready, o_err_len);
    end
    @(negedge i_clk);
    i_nrst = 1'b1;
    check_owners("reset_mid", '{0, 0});
    clear_logs();
    fork
      send(1, 1, 64'h7100_0000_0000_0000);
      send(0, 1, 64'h7200_0000_0000_0000);
    join
    check_drained("reset_prio");
    check_owners("reset_prio", '{0, 1});
  endtask
  task automatic test_stats();
    i_nrst = 1'b0;
    @(negedge i_clk);
    i_nrst = 1'b1;
    send(0, 2, 64'h8000_0000_0000_0000);
    send(0, 2, 64'h8100_0000_0000_0000);
    check_drained("stats");
`ifdef PCIE_DMA_TXARB_STATS_EN
    checks++;
    if (o_pkt_cnt0 !== 32'd2 || o_pkt_cnt1 !== 32'd0) begin
      failures++;
      $display("FAIL stats_cnt got %0d %0d exp 2 0", o_pkt_cnt0, o_pkt_cnt1);
    end
`endif
    checks++;
    if (o_err_len !== 1'b0) begin
      failures++;
      $display("FAIL stats_err got=%b exp=0", o_err_len);
    end
  endtask
  initial begin
    @(negedge i_clk);
    test_reset();
    test_both_3beat();
    test_round_robin();
    test_full_stall();
    test_err_len();
    test_reset_mid_packet();
    test_stats();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
